hazard_detection_unit: RTL and testbench

Load-use hazard detector for the 5-stage pipeline, sitting between the IF/ID and ID/EX pipeline registers. It compares the destination register of a load in EX against the source registers of the instruction in ID. On a match it freezes the PC and the IF/ID register for one cycle and tells the ID-stage control mux to inject a bubble. A small clocked section keeps a saturating stall-cycle counter and a registered copy of the stall flag for performance monitoring.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_stall_counter.sv | 38 +++
 rtl/hazard_detection_unit.sv | 65 ++++++
 tb/tb_hazard_detection_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the load-use hazard detector.
package hazard_pkg;

   localparam int REG_W_DEF = 5;
   localparam int CNT_W_DEF = 16;

   // Register-specifier type at the default width.
   typedef logic [REG_W_DEF-1:0] reg_spec_t;

   // Register 0 is hard-wired zero, so it can never be a real load target.
   localparam reg_spec_t REG_ZERO = 5'd0;

endpackage : hazard_pkg

// File: rtl/hazard_stall_counter.sv
// Saturating event counter: counts cycles with inc high and sticks at all-ones.
module hazard_stall_counter
   import hazard_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: add one when requested unless already saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end
   end

   // Count register, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : hazard_stall_counter

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector between IF/ID and ID/EX: holds PC and IF/ID and
// injects a bubble when the ID instruction reads the register a load in EX
// is about to write. Also keeps a registered stall flag and a stall counter.
module hazard_detection_unit
   import hazard_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ID_EX_memRead,
   input  logic [REG_W-1:0] ID_EX_rt,
   input  logic [REG_W-1:0] IF_ID_rs,
   input  logic [REG_W-1:0] IF_ID_rt,
   output logic             PCWrite,
   output logic             IF_IDWrite,
   output logic             control_select,
   output logic [1:0]       hazard_src,
   output logic             stall_q,
   output logic [CNT_W-1:0] stall_count
);

   logic load_valid;
   logic rs_hit;
   logic rt_hit;
   logic hazard;

   // Match detection; a load to register 0 is never a real dependency, and
   // reset suppresses everything so the pipeline is free to run.
   always_comb begin
      load_valid = rst_n && ID_EX_memRead && (ID_EX_rt != '0);
      rs_hit     = load_valid && (ID_EX_rt == IF_ID_rs);
      rt_hit     = load_valid && (ID_EX_rt == IF_ID_rt);
      hazard     = rs_hit || rt_hit;
   end

   // Pipeline control: freeze PC and IF/ID and select the bubble on a hazard.
   always_comb begin
      PCWrite        = !hazard;
      IF_IDWrite     = !hazard;
      control_select = hazard;
      hazard_src     = {rt_hit, rs_hit};
   end

   // Registered copy of the hazard flag for performance monitoring.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 1'b0;
      end else begin
         stall_q <= hazard;
      end
   end

   // One increment per stalled cycle, so a double match still counts once.
   hazard_stall_counter #(
      .CNT_W (CNT_W)
   ) u_stall_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (hazard),
      .count (stall_count)
   );

endmodule : hazard_detection_unit

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit. A narrow counter is used so
// saturation can be reached in a handful of cycles.
module tb_hazard_detection_unit;

   localparam int REG_W = 5;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             ID_EX_memRead;
   logic [REG_W-1:0] ID_EX_rt;
   logic [REG_W-1:0] IF_ID_rs;
   logic [REG_W-1:0] IF_ID_rt;
   logic             PCWrite;
   logic             IF_IDWrite;
   logic             control_select;
   logic [1:0]       hazard_src;
   logic             stall_q;
   logic [CNT_W-1:0] stall_count;

   int errors = 0;
   int checks = 0;

   hazard_detection_unit #(
      .REG_W (REG_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ID_EX_memRead  (ID_EX_memRead),
      .ID_EX_rt       (ID_EX_rt),
      .IF_ID_rs       (IF_ID_rs),
      .IF_ID_rt       (IF_ID_rt),
      .PCWrite        (PCWrite),
      .IF_IDWrite     (IF_IDWrite),
      .control_select (control_select),
      .hazard_src     (hazard_src),
      .stall_q        (stall_q),
      .stall_count    (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check all combinational outputs against a stall / no-stall expectation.
   task automatic chk_comb(input string tag, input logic stall, input logic [1:0] src);
      $display("step %s: memRead=%0b ex_rt=%0d rs=%0d rt=%0d -> PCW=%0b IFW=%0b sel=%0b src=%b",
               tag, ID_EX_memRead, ID_EX_rt, IF_ID_rs, IF_ID_rt,
               PCWrite, IF_IDWrite, control_select, hazard_src);
      chk({tag, ".PCWrite"},        32'(PCWrite),        32'(!stall));
      chk({tag, ".IF_IDWrite"},     32'(IF_IDWrite),     32'(!stall));
      chk({tag, ".control_select"}, 32'(control_select), 32'(stall));
      chk({tag, ".hazard_src"},     32'(hazard_src),     32'(src));
   endtask

   task automatic chk_regs(input string tag, input logic sq, input int cnt);
      $display("step %s: stall_q=%0b stall_count=%0d", tag, stall_q, stall_count);
      chk({tag, ".stall_q"},     32'(stall_q),     32'(sq));
      chk({tag, ".stall_count"}, 32'(stall_count), 32'(cnt));
   endtask

   task automatic drive(input logic mr, input int ex_rt, input int rs, input int rt);
      ID_EX_memRead = mr;
      ID_EX_rt      = REG_W'(ex_rt);
      IF_ID_rs      = REG_W'(rs);
      IF_ID_rt      = REG_W'(rt);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with a would-be hazard on the inputs: outputs must stay no-stall.
      rst_n = 1'b0;
      drive(1'b1, 2, 2, 2);
      #2;
      chk_comb("reset_forced", 1'b0, 2'b00);
      chk_regs("reset_state", 1'b0, 0);
      tick();
      chk_regs("reset_held", 1'b0, 0);

      // Release reset, no load in EX.
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1, 2, 3);
      #1;
      chk_comb("no_load", 1'b0, 2'b00);
      tick();
      chk_regs("no_load_clk", 1'b0, 0);

      // rs match.
      @(negedge clk);
      drive(1'b1, 2, 2, 3);
      #1;
      chk_comb("rs_hit", 1'b1, 2'b01);
      tick();
      chk_regs("rs_hit_clk", 1'b1, 1);

      // rt match.
      @(negedge clk);
      drive(1'b1, 3, 2, 3);
      #1;
      chk_comb("rt_hit", 1'b1, 2'b10);
      tick();
      chk_regs("rt_hit_clk", 1'b1, 2);

      // Load to an unrelated register, then to register 0.
      @(negedge clk);
      drive(1'b1, 4, 2, 3);
      #1;
      chk_comb("ld_other", 1'b0, 2'b00);
      tick();
      chk_regs("ld_other_clk", 1'b0, 2);
      @(negedge clk);
      drive(1'b1, 0, 2, 3);
      #1;
      chk_comb("ld_r0", 1'b0, 2'b00);

      // Register-zero cases with all specifiers zero.
      drive(1'b0, 0, 0, 0);
      #1;
      chk_comb("zero_noload", 1'b0, 2'b00);
      drive(1'b1, 0, 0, 0);
      #1;
      chk_comb("zero_load", 1'b0, 2'b00);
      tick();
      chk_regs("zero_load_clk", 1'b0, 2);

      // Fresh reset before the double-match run.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_regs("reset2", 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Both sources match: one stall per cycle for three cycles.
      drive(1'b1, 2, 2, 2);
      #1;
      chk_comb("both_hit", 1'b1, 2'b11);
      tick();
      tick();
      tick();
      chk_regs("both_hit_3clk", 1'b1, 3);

      // Reset asserted mid-stall, away from a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      chk_comb("mid_reset", 1'b0, 2'b00);
      chk_regs("mid_reset", 1'b0, 0);
      tick();
      chk_regs("mid_reset_clk", 1'b0, 0);

      // Release with the hazard still present: first edge counts.
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_comb("post_reset", 1'b1, 2'b11);
      tick();
      chk_regs("post_reset_clk", 1'b1, 1);

      // Drive the counter up to all-ones, then one more stall must hold it.
      for (int i = 0; i < 14; i++) tick();
      chk_regs("saturate", 1'b1, 15);
      tick();
      chk_regs("saturate_hold", 1'b1, 15);

      // Hazard cleared: flag drops, count stays.
      @(negedge clk);
      drive(1'b0, 2, 2, 2);
      #1;
      chk_comb("release", 1'b0, 2'b00);
      tick();
      chk_regs("release_clk", 1'b0, 15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so the run can never hang.
   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule : tb_hazard_detection_unit
